// File: rtl/ttt_game_core.sv
// N x N, K-in-a-row game engine: holds the board, alternates turns, validates
// moves and finds wins/draws with a one-cell-per-cycle line scanner.
module ttt_game_core #(
    parameter int N  = 3,
    parameter int K  = 3,
    parameter int IW = $clog2(N*N),
    parameter int CW = $clog2(N*N+1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             new_game,
    input  logic             move_valid,
    input  logic [IW-1:0]    move_idx,
    output logic             move_ready,
    output logic             move_done,
    output logic             move_err,
    output logic [2*N*N-1:0] board,
    output logic             turn_o,
    output logic [1:0]       result,
    output logic [CW-1:0]    move_count
);
    typedef enum logic [1:0] {IDLE = 2'd0, SCAN = 2'd1, FIN = 2'd2} state_t;

    localparam int            CELLS   = N*N;
    localparam logic [CW-1:0] CELLS_C = CW'(N*N);

    state_t             state_r;
    logic [2*N*N-1:0]   board_r;
    logic               turn_r;
    logic [1:0]         result_r;
    logic [CW-1:0]      count_r;
    logic               ready_r;
    logic               done_r;
    logic               err_r;
    logic signed [4:0]  ptr_row_r, ptr_col_r, org_row_r, org_col_r;
    logic [2:0]         dir_r;
    logic [3:0]         run_r;

    logic [1:0]         mover_s;
    int                 req_idx_s, rd_idx_s;
    logic               req_oob_s, req_bad_s;
    logic signed [4:0]  req_row_s, req_col_s;
    logic signed [4:0]  dr_s, dc_s, nr_s, nc_s;
    logic               in_bnd_s, same_s, hit_k_s, scan_end_s;
    int                 nb_idx_s;
    logic [1:0]         fin_result_s;

    // Request decode: legality of the requested cell and its row/column.
    always_comb begin
        mover_s   = turn_r ? 2'b10 : 2'b01;
        req_idx_s = 32'(move_idx);
        req_oob_s = (req_idx_s >= CELLS);
        rd_idx_s  = req_oob_s ? 32'sd0 : req_idx_s;
        req_bad_s = req_oob_s || (board_r[2*rd_idx_s +: 2] != 2'b00) || (result_r != 2'b00);
        req_row_s = 5'(rd_idx_s / N);
        req_col_s = 5'(rd_idx_s % N);
    end

    // Scanner step: neighbour of the pointer in the current direction.
    always_comb begin
        case (dir_r)
            3'd0:    begin dr_s =  5'sd0; dc_s =  5'sd1; end
            3'd1:    begin dr_s =  5'sd0; dc_s = -5'sd1; end
            3'd2:    begin dr_s =  5'sd1; dc_s =  5'sd0; end
            3'd3:    begin dr_s = -5'sd1; dc_s =  5'sd0; end
            3'd4:    begin dr_s =  5'sd1; dc_s =  5'sd1; end
            3'd5:    begin dr_s = -5'sd1; dc_s = -5'sd1; end
            3'd6:    begin dr_s =  5'sd1; dc_s = -5'sd1; end
            3'd7:    begin dr_s = -5'sd1; dc_s =  5'sd1; end
            default: begin dr_s =  5'sd0; dc_s =  5'sd0; end
        endcase
        nr_s       = ptr_row_r + dr_s;
        nc_s       = ptr_col_r + dc_s;
        in_bnd_s   = (nr_s >= 5'sd0) && (int'(nr_s) < N) && (nc_s >= 5'sd0) && (int'(nc_s) < N);
        nb_idx_s   = in_bnd_s ? (int'(nr_s) * N + int'(nc_s)) : 32'sd0;
        same_s     = in_bnd_s && (board_r[2*nb_idx_s +: 2] == mover_s);
        hit_k_s    = same_s && ((run_r + 4'd1) == 4'(K));
        scan_end_s = hit_k_s || (!same_s && (dir_r == 3'd7));
        // Win outranks draw; count_r already includes the stone being scanned.
        if (hit_k_s) begin
            fin_result_s = mover_s;
        end else if (count_r == CELLS_C) begin
            fin_result_s = 2'b11;
        end else begin
            fin_result_s = 2'b00;
        end
    end

    // Game state machine: move acceptance, line scan and result update.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r   <= IDLE;
            board_r   <= '0;
            turn_r    <= 1'b0;
            result_r  <= 2'b00;
            count_r   <= '0;
            ready_r   <= 1'b1;
            done_r    <= 1'b0;
            err_r     <= 1'b0;
            ptr_row_r <= 5'sd0;
            ptr_col_r <= 5'sd0;
            org_row_r <= 5'sd0;
            org_col_r <= 5'sd0;
            dir_r     <= 3'd0;
            run_r     <= 4'd0;
        end else if (new_game) begin
            state_r   <= IDLE;
            board_r   <= '0;
            turn_r    <= 1'b0;
            result_r  <= 2'b00;
            count_r   <= '0;
            ready_r   <= 1'b1;
            done_r    <= 1'b0;
            err_r     <= 1'b0;
            ptr_row_r <= 5'sd0;
            ptr_col_r <= 5'sd0;
            org_row_r <= 5'sd0;
            org_col_r <= 5'sd0;
            dir_r     <= 3'd0;
            run_r     <= 4'd0;
        end else begin
            done_r <= 1'b0;
            err_r  <= 1'b0;
            case (state_r)
                IDLE: begin
                    if (move_valid && ready_r) begin
                        if (req_bad_s) begin
                            err_r <= 1'b1;
                        end else begin
                            board_r[2*rd_idx_s +: 2] <= mover_s;
                            count_r   <= count_r + {{(CW-1){1'b0}}, 1'b1};
                            ptr_row_r <= req_row_s;
                            ptr_col_r <= req_col_s;
                            org_row_r <= req_row_s;
                            org_col_r <= req_col_s;
                            dir_r     <= 3'd0;
                            run_r     <= 4'd1;
                            ready_r   <= 1'b0;
                            state_r   <= SCAN;
                        end
                    end
                end
                SCAN: begin
                    if (scan_end_s) begin
                        state_r  <= FIN;
                        done_r   <= 1'b1;
                        result_r <= fin_result_s;
                        if (fin_result_s == 2'b00) begin
                            turn_r <= ~turn_r;
                        end
                    end else if (same_s) begin
                        run_r     <= run_r + 4'd1;
                        ptr_row_r <= nr_s;
                        ptr_col_r <= nc_s;
                    end else begin
                        // Odd direction closes a pair, so the run restarts.
                        dir_r     <= dir_r + 3'd1;
                        ptr_row_r <= org_row_r;
                        ptr_col_r <= org_col_r;
                        if (dir_r[0]) begin
                            run_r <= 4'd1;
                        end
                    end
                end
                FIN: begin
                    state_r <= IDLE;
                    ready_r <= 1'b1;
                end
                default: begin
                    state_r <= IDLE;
                    ready_r <= 1'b1;
                end
            endcase
        end
    end

    assign move_ready = ready_r;
    assign move_done  = done_r;
    assign move_err   = err_r;
    assign board      = board_r;
    assign turn_o     = turn_r;
    assign result     = result_r;
    assign move_count = count_r;

endmodule

// File: tb/tb_ttt_game_core.sv
// Directed bench for ttt_game_core: a 3x3/K=3 instance and a 5x5/K=4 instance.
module tb_ttt_game_core;
    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        ng_a = 1'b0, ng_b = 1'b0;
    logic        val_a = 1'b0, val_b = 1'b0;
    logic [3:0]  idx_a = 4'd0;
    logic [4:0]  idx_b = 5'd0;

    logic        rdy_a, done_a, err_a, turn_a;
    logic [17:0] board_a;
    logic [1:0]  res_a;
    logic [3:0]  cnt_a;

    logic        rdy_b, done_b, err_b, turn_b;
    logic [49:0] board_b;
    logic [1:0]  res_b;
    logic [4:0]  cnt_b;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    ttt_game_core #(.N(3), .K(3)) dut_a (
        .clk(clk), .rst(rst), .new_game(ng_a), .move_valid(val_a), .move_idx(idx_a),
        .move_ready(rdy_a), .move_done(done_a), .move_err(err_a), .board(board_a),
        .turn_o(turn_a), .result(res_a), .move_count(cnt_a)
    );

    ttt_game_core #(.N(5), .K(4)) dut_b (
        .clk(clk), .rst(rst), .new_game(ng_b), .move_valid(val_b), .move_idx(idx_b),
        .move_ready(rdy_b), .move_done(done_b), .move_err(err_b), .board(board_b),
        .turn_o(turn_b), .result(res_b), .move_count(cnt_b)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Issue one request; lat is the cycle (request = cycle 0) of done/err, 0 on timeout.
    task automatic mv(input int sel, input int idx, output int lat, output logic dn,
                      output logic er, output logic [63:0] b1);
        lat = 0; dn = 1'b0; er = 1'b0; b1 = '0;
        @(negedge clk);
        if (sel == 0) begin val_a = 1'b1; idx_a = 4'(idx); end
        else          begin val_b = 1'b1; idx_b = 5'(idx); end
        @(posedge clk);
        #1;
        val_a = 1'b0;
        val_b = 1'b0;
        for (int c = 1; c <= 40; c++) begin
            @(negedge clk);
            if (c == 1) b1 = (sel == 0) ? 64'(board_a) : 64'(board_b);
            if ((sel == 0) ? (done_a || err_a) : (done_b || err_b)) begin
                lat = c;
                dn  = (sel == 0) ? done_a : done_b;
                er  = (sel == 0) ? err_a  : err_b;
                break;
            end
        end
    endtask

    task automatic ng(input int sel);
        @(negedge clk);
        if (sel == 0) ng_a = 1'b1; else ng_b = 1'b1;
        @(posedge clk);
        #1;
        ng_a = 1'b0;
        ng_b = 1'b0;
    endtask

    initial begin
        int          lat;
        logic        dn, er, seen;
        logic [63:0] b1;
        int          seq_a [5];
        int          draw_seq [9];
        int          seq_b [7];
        seq_a    = '{0, 3, 1, 4, 2};
        draw_seq = '{0, 1, 2, 4, 3, 5, 7, 6, 8};
        seq_b    = '{1, 0, 6, 2, 11, 3, 16};

        // Reset and idle
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk("rst_board", 64'(board_a), 64'd0);
        chk("rst_result", 64'(res_a), 64'd0);
        chk("rst_turn", 64'(turn_a), 64'd0);
        chk("rst_count", 64'(cnt_a), 64'd0);
        chk("rst_ready", 64'(rdy_a), 64'd1);
        chk("rst_pulses", 64'({done_a, err_a}), 64'd0);
        chk("rst_b_ready", 64'(rdy_b), 64'd1);

        // First move to the centre: isolated stone, 8 scan steps
        mv(0, 4, lat, dn, er, b1);
        chk("first_board_c1", b1, 64'h100);
        chk("first_lat", 64'(lat), 64'd9);
        chk("first_done", 64'(dn), 64'd1);
        chk("first_turn", 64'(turn_a), 64'd1);
        chk("first_count", 64'(cnt_a), 64'd1);
        chk("first_result", 64'(res_a), 64'd0);

        // Illegal: occupied cell and out-of-range index
        mv(0, 4, lat, dn, er, b1);
        chk("occ_err_lat", 64'(lat), 64'd1);
        chk("occ_err", 64'({dn, er}), 64'b01);
        chk("occ_ready", 64'(rdy_a), 64'd1);
        chk("occ_board", 64'(board_a), 64'h100);
        chk("occ_turn", 64'(turn_a), 64'd1);
        chk("occ_count", 64'(cnt_a), 64'd1);
        mv(0, 9, lat, dn, er, b1);
        chk("oob9_err", 64'({lat[3:0], dn, er}), {58'd0, 4'd1, 2'b01});
        mv(0, 15, lat, dn, er, b1);
        chk("oob15_err", 64'({lat[3:0], dn, er}), {58'd0, 4'd1, 2'b01});
        chk("oob_board", 64'(board_a), 64'h100);

        // Row win with early exit
        ng(0);
        @(negedge clk);
        chk("ng_board", 64'(board_a), 64'd0);
        chk("ng_turn", 64'(turn_a), 64'd0);
        for (int i = 0; i < 5; i++) mv(0, seq_a[i], lat, dn, er, b1);
        chk("row_lat", 64'(lat), 64'd4);
        chk("row_result", 64'(res_a), 64'b01);
        chk("row_turn", 64'(turn_a), 64'd0);
        chk("row_count", 64'(cnt_a), 64'd5);
        mv(0, 5, lat, dn, er, b1);
        chk("after_win_err", 64'({lat[3:0], dn, er}), {58'd0, 4'd1, 2'b01});
        chk("after_win_count", 64'(cnt_a), 64'd5);

        // Draw
        ng(0);
        for (int i = 0; i < 9; i++) mv(0, draw_seq[i], lat, dn, er, b1);
        chk("draw_last_lat", 64'(lat), 64'd10);
        chk("draw_result", 64'(res_a), 64'b11);
        chk("draw_count", 64'(cnt_a), 64'd9);
        chk("draw_turn", 64'(turn_a), 64'd0);
        chk("draw_board", 64'(board_a), 64'h16A59);
        mv(0, 0, lat, dn, er, b1);
        chk("after_draw_err", 64'({lat[3:0], dn, er}), {58'd0, 4'd1, 2'b01});

        // 5x5, K=4: column win
        for (int i = 0; i < 7; i++) mv(1, seq_b[i], lat, dn, er, b1);
        chk("b_win_lat", 64'(lat), 64'd7);
        chk("b_result", 64'(res_b), 64'b01);
        chk("b_count", 64'(cnt_b), 64'd7);
        chk("b_turn", 64'(turn_b), 64'd0);

        // Abort a scan with new_game
        ng(1);
        @(negedge clk);
        val_b = 1'b1;
        idx_b = 5'd12;
        @(posedge clk);
        #1;
        val_b = 1'b0;
        @(negedge clk);
        chk("abort_board_c1", 64'(board_b), 64'h1000000);
        @(negedge clk);
        chk("abort_ready_scan", 64'(rdy_b), 64'd0);
        ng_b = 1'b1;
        @(posedge clk);
        #1;
        ng_b = 1'b0;
        @(negedge clk);
        chk("abort_board", 64'(board_b), 64'd0);
        chk("abort_count", 64'(cnt_b), 64'd0);
        chk("abort_state", 64'({rdy_b, turn_b, res_b, done_b, err_b}), 64'b100000);
        seen = 1'b0;
        for (int c = 0; c < 12; c++) begin
            @(negedge clk);
            if (done_b) seen = 1'b1;
        end
        chk("abort_no_done", 64'(seen), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
